// File: rtl/arriskv_mem_responder.sv
// Word-organised BRAM responder for the core memory port: one-cycle registered reads,
// post-reset array clear, and sticky capture of the first illegal access.
module arriskv_mem_responder #(
   parameter int unsigned           depth_p     = 1024,
   parameter int unsigned           wd_data_p   = 32,
   parameter int unsigned           wd_addr_p   = 32,
   parameter logic [wd_addr_p-1:0]  base_addr_p = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [wd_addr_p-1:0] i_mem_rd_addr,
   output logic [wd_data_p-1:0] o_mem_rd_data,
   input  logic                 i_mem_wr_en,
   input  logic [wd_addr_p-1:0] i_mem_wr_addr,
   input  logic [wd_data_p-1:0] i_mem_wr_data,
   output logic                 o_busy,
   output logic                 o_err,
   output logic [wd_addr_p-1:0] o_err_addr
);

   localparam int unsigned          idx_w   = (depth_p > 1) ? $clog2(depth_p) : 1;
   localparam logic [wd_addr_p-1:0] depth_w = wd_addr_p'(depth_p);
   localparam logic [idx_w-1:0]     last_w  = idx_w'(depth_p - 1);

   typedef enum logic {CLEAR, READY} state_t;

   state_t state, state_n;
   logic [idx_w-1:0] clr_cnt, clr_cnt_n;

   logic [wd_data_p-1:0] mem [depth_p];
   logic [wd_data_p-1:0] rd_word;
   logic [wd_data_p-1:0] byp_data;
   logic                 byp_sel;
   logic                 rd_zero;

   logic [wd_addr_p-1:0] rd_off, wr_off;
   logic [idx_w-1:0]     rd_idx, wr_idx;
   logic                 rd_legal, wr_legal;

   logic                 we;
   logic [idx_w-1:0]     waddr;
   logic [wd_data_p-1:0] wdata;

   // Offsets are taken at address width; the >= check rejects wrapped addresses below base.
   always_comb begin
      rd_off   = i_mem_rd_addr - base_addr_p;
      wr_off   = i_mem_wr_addr - base_addr_p;
      rd_idx   = idx_w'(rd_off >> 2);
      wr_idx   = idx_w'(wr_off >> 2);
      rd_legal = (i_mem_rd_addr >= base_addr_p) && (i_mem_rd_addr[1:0] == 2'b00)
                 && ((rd_off >> 2) < depth_w);
      wr_legal = (i_mem_wr_addr >= base_addr_p) && (i_mem_wr_addr[1:0] == 2'b00)
                 && ((wr_off >> 2) < depth_w);
   end

   always_comb begin
      state_n   = state;
      clr_cnt_n = clr_cnt;
      if (state == CLEAR) begin
         clr_cnt_n = clr_cnt + 1'b1;
         if (clr_cnt == last_w) begin
            state_n   = READY;
            clr_cnt_n = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state   <= state_n;
         clr_cnt <= clr_cnt_n;
      end
   end

   assign o_busy = (state == CLEAR);

   // Single write port shared by the clear sequencer and core writes.
   always_comb begin
      we    = 1'b0;
      waddr = '0;
      wdata = '0;
      if (!rst) begin
         if (state == CLEAR) begin
            we    = 1'b1;
            waddr = clr_cnt;
         end else if (i_mem_wr_en && wr_legal) begin
            we    = 1'b1;
            waddr = wr_idx;
            wdata = i_mem_wr_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      rd_word <= mem[rd_idx];
   end

   // Write-first bypass and zero-forcing are registered alongside the read-old BRAM output.
   always_ff @(posedge clk) begin
      if (rst) begin
         byp_sel  <= 1'b0;
         byp_data <= '0;
         rd_zero  <= 1'b1;
      end else begin
         byp_sel  <= (state == READY) && i_mem_wr_en && wr_legal && rd_legal
                     && (wr_idx == rd_idx);
         byp_data <= i_mem_wr_data;
         rd_zero  <= (state != READY) || !rd_legal;
      end
   end

   assign o_mem_rd_data = rd_zero ? '0 : (byp_sel ? byp_data : rd_word);

   always_ff @(posedge clk) begin
      if (rst) begin
         o_err      <= 1'b0;
         o_err_addr <= '0;
      end else if (state == READY && !o_err) begin
         if (i_mem_wr_en && !wr_legal) begin
            o_err      <= 1'b1;
            o_err_addr <= i_mem_wr_addr;
         end else if (!rd_legal) begin
            o_err      <= 1'b1;
            o_err_addr <= i_mem_rd_addr;
         end
      end
   end

endmodule

// File: tb/tb_arriskv_mem_responder.sv
// Directed and randomized checks of arriskv_mem_responder (depth 16) against a
// word-array reference model.
module tb_arriskv_mem_responder;

   localparam int unsigned DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] rd_addr = '0;
   logic [31:0] rd_data;
   logic        wr_en = 1'b0;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        busy;
   logic        err;
   logic [31:0] err_addr;

   int unsigned tests = 0;
   int unsigned fails = 0;

   logic [31:0] model [DEPTH];
   int unsigned clr_left = 0;
   logic [31:0] exp_rd = '0;
   logic        exp_err = 1'b0;
   logic [31:0] exp_eaddr = '0;

   arriskv_mem_responder #(
      .depth_p     (DEPTH),
      .wd_data_p   (32),
      .wd_addr_p   (32),
      .base_addr_p (32'h0000_0000)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_mem_rd_addr (rd_addr),
      .o_mem_rd_data (rd_data),
      .i_mem_wr_en   (wr_en),
      .i_mem_wr_addr (wr_addr),
      .i_mem_wr_data (wr_data),
      .o_busy        (busy),
      .o_err         (err),
      .o_err_addr    (err_addr)
   );

   always #5 clk = ~clk;

   function automatic logic legal(input logic [31:0] a);
      return (a % 4 == 0) && (a / 4 < DEPTH);
   endfunction

   // One clock: drive inputs, advance the model across the edge, then check all outputs.
   task automatic step(input logic r, input logic [31:0] ra, input logic we,
                       input logic [31:0] wa, input logic [31:0] wd);
      rst = r; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd;
      @(posedge clk);
      if (r) begin
         clr_left  = DEPTH;
         exp_rd    = '0;
         exp_err   = 1'b0;
         exp_eaddr = '0;
         for (int i = 0; i < DEPTH; i++) model[i] = '0;
      end else if (clr_left != 0) begin
         exp_rd   = '0;
         clr_left = clr_left - 1;
      end else begin
         if (!legal(ra))                        exp_rd = '0;
         else if (we && legal(wa) && wa == ra)  exp_rd = wd;
         else                                   exp_rd = model[ra / 4];
         if (we && legal(wa)) model[wa / 4] = wd;
         if (!exp_err) begin
            if (we && !legal(wa)) begin exp_err = 1'b1; exp_eaddr = wa; end
            else if (!legal(ra))  begin exp_err = 1'b1; exp_eaddr = ra; end
         end
      end
      #1;
      tests++;
      assert (rd_data === exp_rd) else begin
         fails++; $error("FAIL rd_data got %h exp %h", rd_data, exp_rd);
      end
      tests++;
      assert (busy === (clr_left != 0)) else begin
         fails++; $error("FAIL busy got %b exp %b", busy, clr_left != 0);
      end
      tests++;
      assert (err === exp_err) else begin
         fails++; $error("FAIL err got %b exp %b", err, exp_err);
      end
      tests++;
      assert (err_addr === exp_eaddr) else begin
         fails++; $error("FAIL err_addr got %h exp %h", err_addr, exp_eaddr);
      end
   endtask

   task automatic idle(input int unsigned n, input logic [31:0] ra);
      for (int unsigned i = 0; i < n; i++) step(1'b0, ra, 1'b0, '0, '0);
   endtask

   initial begin
      logic [31:0] ra, wa, wd;
      logic        we;

      // Reset, then clear with reads of 0x0/0x3C and a dropped write to 0x4.
      step(1'b1, '0, 1'b0, '0, '0);
      step(1'b1, '0, 1'b0, '0, '0);
      step(1'b0, 32'h3C, 1'b1, 32'h4, 32'hFFFF_FFFF);
      idle(14, 32'h0);
      idle(1, 32'h3C);
      idle(2, 32'h3C);
      idle(1, 32'h4);
      idle(1, 32'h0);

      // Write then read next cycle.
      step(1'b0, '0, 1'b1, 32'h8, 32'hCAFE_BABE);
      step(1'b0, 32'h8, 1'b0, '0, '0);
      idle(1, 32'h0);

      // Write-first collision and independent neighbour.
      step(1'b0, '0, 1'b1, 32'h14, 32'h5555_AAAA);
      step(1'b0, 32'h10, 1'b1, 32'h10, 32'h1234_5678);
      step(1'b0, 32'h14, 1'b1, 32'h10, 32'h8765_4321);
      idle(1, 32'h10);

      // Misaligned write, then out-of-range read; first address stays captured.
      step(1'b0, 32'h8, 1'b1, 32'h41, 32'h1);
      step(1'b0, 32'h40, 1'b0, '0, '0);
      idle(1, 32'h40);
      idle(1, 32'h8);

      // Reset mid-clear at clr_cnt=7 after a write of 0xAA to 0x0.
      step(1'b0, '0, 1'b1, 32'h0, 32'hAA);
      idle(1, 32'h0);
      step(1'b1, '0, 1'b0, '0, '0);
      idle(7, 32'h0);
      step(1'b1, '0, 1'b0, '0, '0);
      idle(16, 32'h0);
      idle(2, 32'h0);

      // Randomized traffic, mostly legal, with occasional illegal addresses.
      for (int i = 0; i < 300; i++) begin
         ra = $urandom_range(0, DEPTH - 1) * 4;
         wa = $urandom_range(0, DEPTH - 1) * 4;
         if ($urandom_range(0, 7) == 0) ra = $urandom_range(0, DEPTH * 4 + 8);
         if ($urandom_range(0, 15) == 0) wa = $urandom_range(0, DEPTH * 4 + 8);
         if ($urandom_range(0, 3) == 0) wa = ra;
         we = 1'($urandom_range(0, 1));
         wd = $urandom;
         step(1'b0, ra, we, wa, wd);
         if (i == 150) begin
            step(1'b1, '0, 1'b0, '0, '0);
            idle(DEPTH, 32'h0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
